// File: rtl/packet_arb_pkg.sv
// Shared types and small index helpers for the weighted round-robin packet arbiter.
package packet_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

    // Increment a channel index, wrapping at n (valid for any n, not only powers of two).
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

    // A programmed weight of zero still allows one packet per turn.
    function automatic int eff_weight(input int w);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_prio_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping to 0.
module rr_prio_picker #(
    parameter int N = 8
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         onehot,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    // Lower copy keeps only bits >= ptr, upper copy supplies the wrapped-around candidates.
    always_comb begin
        logic [N-1:0]   lo_mask;
        logic [2*N-1:0] dbl;
        logic           found;
        // NOTE: every output gets a default before the search loop so no path leaves a latch.
        onehot  = '0;
        idx     = '0;
        found   = 1'b0;
        lo_mask = {N{1'b1}} << ptr;
        dbl     = {req, req & lo_mask};
        for (int i = 0; i < 2 * N; i++) begin
            if (!found && dbl[i]) begin
                found = 1'b1;
                idx   = (i >= N) ? IW'(i - N) : IW'(i);
            end
        end
        any         = |req;
        onehot[idx] = any;
    end

endmodule

// File: rtl/packet_wrr_arbiter.sv
// Weighted round-robin packet arbiter: grant locks for a whole packet, each channel
// may send up to its weight in packets per turn, stalled owners are released by timeout.
module packet_wrr_arbiter
    import packet_arb_pkg::*;
#(
    parameter int N             = 8,
    parameter int WEIGHT_W      = 4,
    parameter int STALL_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req,
    input  logic [N-1:0]          req_is_last,
    input  logic [N*WEIGHT_W-1:0] weights,
    input  logic                  ready,
    output logic [N-1:0]          grants,
    output logic [$clog2(N)-1:0]  grant_idx,
    output logic                  grant_valid,
    output logic                  pkt_done,
    output logic                  timeout_err
);

    localparam int IW        = $clog2(N);
    localparam int SW        = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;
    localparam int STALL_MAX = (STALL_TIMEOUT > 0) ? STALL_TIMEOUT - 1 : 0;

    arb_state_t          state;
    logic [IW-1:0]       ptr;
    logic [IW-1:0]       owner;
    logic [IW-1:0]       last_owner;
    logic [WEIGHT_W-1:0] credit;
    logic [SW-1:0]       stall_cnt;

    logic [N-1:0]        pick_oh;
    logic [IW-1:0]       pick_idx;
    logic                pick_any;
    logic [N-1:0]        owner_oh;
    logic [IW-1:0]       cur_idx;
    logic                cur_valid;
    logic                xfer;
    logic                last_xfer;
    logic [WEIGHT_W-1:0] cur_weight;
    logic [WEIGHT_W-1:0] credit_next;
    logic                turn_over;
    logic                timeout_hit;

    rr_prio_picker #(.N(N)) u_picker (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Grant selection: the locked owner wins regardless of req; reset forces grants low.
    always_comb begin
        owner_oh = '0;
        for (int i = 0; i < N; i++) begin
            owner_oh[i] = (owner == IW'(i));
        end
        cur_idx     = (state == ARB_LOCKED) ? owner : pick_idx;
        cur_valid   = rst && ((state == ARB_LOCKED) || pick_any);
        grants      = !rst ? '0 : ((state == ARB_LOCKED) ? owner_oh : pick_oh);
        grant_idx   = cur_valid ? cur_idx : '0;
        grant_valid = |grants;
    end

    // Transfer, credit and timeout decisions for the current cycle.
    always_comb begin
        xfer        = cur_valid && req[cur_idx] && ready;
        last_xfer   = xfer && req_is_last[cur_idx];
        cur_weight  = weights[int'(cur_idx) * WEIGHT_W +: WEIGHT_W];
        credit_next = (cur_idx != last_owner) ? WEIGHT_W'(1) : credit + WEIGHT_W'(1);
        turn_over   = int'(credit_next) >= eff_weight(int'(cur_weight));
        timeout_hit = (STALL_TIMEOUT != 0) && (stall_cnt == SW'(STALL_MAX));
    end

    // Arbiter FSM, credit/stall counters and registered status pulses.
    // NOTE: every register here, including the pulse outputs, is cleared by the async reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ARB_IDLE;
            ptr         <= '0;
            owner       <= '0;
            last_owner  <= '0;
            credit      <= '0;
            stall_cnt   <= '0;
            pkt_done    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every branch sees this cycle's register values.
            pkt_done    <= 1'b0;
            timeout_err <= 1'b0;
            if (last_xfer) begin
                // A last beat always wins over a coincident timeout.
                state      <= ARB_IDLE;
                stall_cnt  <= '0;
                last_owner <= cur_idx;
                pkt_done   <= 1'b1;
                if (turn_over) begin
                    ptr    <= IW'(wrap_inc(int'(cur_idx), N));
                    credit <= '0;
                end else begin
                    ptr    <= cur_idx;
                    credit <= credit_next;
                end
            end else if (state == ARB_IDLE) begin
                if (xfer) begin
                    state     <= ARB_LOCKED;
                    owner     <= cur_idx;
                    stall_cnt <= '0;
                end
            end else if (req[owner]) begin
                stall_cnt <= '0;
            end else if (timeout_hit) begin
                state       <= ARB_IDLE;
                ptr         <= IW'(wrap_inc(int'(owner), N));
                credit      <= '0;
                stall_cnt   <= '0;
                timeout_err <= 1'b1;
            end else if (STALL_TIMEOUT != 0) begin
                stall_cnt <= stall_cnt + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_packet_wrr_arbiter.sv
// Directed testbench for packet_wrr_arbiter (N=8, WEIGHT_W=4, STALL_TIMEOUT=16).
module tb_packet_wrr_arbiter;

    localparam int N  = 8;
    localparam int WW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  req_is_last;
    logic [N*WW-1:0] weights;
    logic          ready;
    logic [N-1:0]  grants;
    logic [2:0]    grant_idx;
    logic          grant_valid;
    logic          pkt_done;
    logic          timeout_err;

    int n_vec = 0;
    int n_err = 0;

    packet_wrr_arbiter #(.N(N), .WEIGHT_W(WW), .STALL_TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_is_last (req_is_last),
        .weights     (weights),
        .ready       (ready),
        .grants      (grants),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .pkt_done    (pkt_done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Apply inputs on the falling edge and let the combinational outputs settle.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic rdy);
        @(negedge clk);
        req         = r;
        req_is_last = l;
        ready       = rdy;
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        req         = '0;
        req_is_last = '0;
        ready       = 1'b1;
        weights     = {N{4'd1}};
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        weights     = {N{4'd1}};
        ready       = 1'b1;
        req         = 8'hFF;
        req_is_last = 8'hFF;
        @(negedge clk);
        #1;
        n_vec++;
        if (grants !== 8'h00) begin
            n_err++; $display("FAIL reset_grants: got %h expected 00", grants);
        end
        n_vec++;
        if (grant_valid !== 1'b0 || grant_idx !== 3'd0) begin
            n_err++; $display("FAIL reset_valid_idx: got valid=%b idx=%0d expected 0/0", grant_valid, grant_idx);
        end
        n_vec++;
        if (pkt_done !== 1'b0 || timeout_err !== 1'b0) begin
            n_err++; $display("FAIL reset_pulses: got done=%b tmo=%b expected 0/0", pkt_done, timeout_err);
        end
        @(negedge clk);
        rst = 1'b1;
        step(8'h00, 8'h00, 1'b1);
        n_vec++;
        if (grants !== 8'h00 || grant_valid !== 1'b0) begin
            n_err++; $display("FAIL idle_no_req: got grants=%h valid=%b expected 00/0", grants, grant_valid);
        end
    endtask

    task automatic test_rotation();
        logic [7:0] exp_g [6] = '{8'h01, 8'h02, 8'h08, 8'h10, 8'h80, 8'h01};
        logic [2:0] exp_i [6] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd7, 3'd0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(8'h9B, 8'h9B, 1'b1);
            n_vec++;
            if (grants !== exp_g[i] || grant_idx !== exp_i[i]) begin
                n_err++; $display("FAIL rotation[%0d]: got grants=%h idx=%0d expected %h/%0d", i, grants, grant_idx, exp_g[i], exp_i[i]);
            end
            n_vec++;
            if (pkt_done !== (i > 0)) begin
                n_err++; $display("FAIL rotation_done[%0d]: got %b expected %b", i, pkt_done, (i > 0));
            end
        end
    endtask

    task automatic test_lock_gap();
        logic [7:0] r_tab [5] = '{8'h03, 8'h02, 8'h03, 8'h03, 8'h03};
        logic [7:0] l_tab [5] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
        logic [7:0] g_tab [5] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02};
        logic       d_tab [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(r_tab[i], l_tab[i], 1'b1);
            n_vec++;
            if (grants !== g_tab[i] || pkt_done !== d_tab[i]) begin
                n_err++; $display("FAIL lock_gap[%0d]: got grants=%h done=%b expected %h/%b", i, grants, pkt_done, g_tab[i], d_tab[i]);
            end
        end
    endtask

    task automatic test_weights();
        logic [7:0] exp_g [8] = '{8'h01, 8'h01, 8'h01, 8'h02, 8'h01, 8'h01, 8'h01, 8'h02};
        do_reset();
        weights = 32'h1111_1113;
        for (int i = 0; i < 8; i++) begin
            step(8'h03, 8'h03, 1'b1);
            n_vec++;
            if (grants !== exp_g[i]) begin
                n_err++; $display("FAIL weight3[%0d]: got %h expected %h", i, grants, exp_g[i]);
            end
        end
    endtask

    task automatic test_weight_zero();
        logic [7:0] exp_g [4] = '{8'h01, 8'h02, 8'h01, 8'h02};
        do_reset();
        weights = '0;
        for (int i = 0; i < 4; i++) begin
            step(8'h03, 8'h03, 1'b1);
            n_vec++;
            if (grants !== exp_g[i]) begin
                n_err++; $display("FAIL weight0[%0d]: got %h expected %h", i, grants, exp_g[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(8'h04, 8'h04, 1'b0);
            n_vec++;
            if (grants !== 8'h04 || pkt_done !== 1'b0) begin
                n_err++; $display("FAIL stall_ready[%0d]: got grants=%h done=%b expected 04/0", i, grants, pkt_done);
            end
        end
        step(8'h04, 8'h04, 1'b1);
        n_vec++;
        if (grants !== 8'h04 || pkt_done !== 1'b0) begin
            n_err++; $display("FAIL ready_release: got grants=%h done=%b expected 04/0", grants, pkt_done);
        end
        // ptr=3 shows up as ch3 beating ch0 and ch2.
        step(8'h0D, 8'h0D, 1'b1);
        n_vec++;
        if (pkt_done !== 1'b1 || grants !== 8'h08) begin
            n_err++; $display("FAIL ready_done_ptr: got done=%b grants=%h expected 1/08", pkt_done, grants);
        end
    endtask

    task automatic test_timeout();
        int pulses;
        do_reset();
        step(8'h02, 8'h00, 1'b1);
        n_vec++;
        if (grants !== 8'h02) begin
            n_err++; $display("FAIL tmo_lock: got %h expected 02", grants);
        end
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            step(8'h20, 8'h00, 1'b1);
            if (timeout_err === 1'b1) pulses++;
            n_vec++;
            if (grants !== 8'h02) begin
                n_err++; $display("FAIL tmo_hold[%0d]: got %h expected 02", i, grants);
            end
        end
        step(8'h20, 8'h00, 1'b1);
        n_vec++;
        if (timeout_err !== 1'b1 || grants !== 8'h20) begin
            n_err++; $display("FAIL tmo_release: got tmo=%b grants=%h expected 1/20", timeout_err, grants);
        end
        step(8'h20, 8'h00, 1'b1);
        n_vec++;
        if (timeout_err !== 1'b0 || pulses !== 0) begin
            n_err++; $display("FAIL tmo_single_pulse: got tmo=%b early=%0d expected 0/0", timeout_err, pulses);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        step(8'h40, 8'h00, 1'b1);
        step(8'h40, 8'h00, 1'b1);
        n_vec++;
        if (grants !== 8'h40) begin
            n_err++; $display("FAIL mid_lock: got %h expected 40", grants);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        if (grants !== 8'h00 || grant_valid !== 1'b0) begin
            n_err++; $display("FAIL mid_reset_grants: got %h/%b expected 00/0", grants, grant_valid);
        end
        @(negedge clk);
        rst         = 1'b1;
        req         = 8'hC1;
        req_is_last = 8'h00;
        #1;
        n_vec++;
        if (grants !== 8'h01) begin
            n_err++; $display("FAIL mid_reset_prio: got %h expected 01", grants);
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_lock_gap();
        test_weights();
        test_weight_zero();
        test_backpressure();
        test_timeout();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
